cv32e40p_tmr_scrub_replicator: RTL

CV32E40P_TMR_SCRUB_REPLICATOR -- requirements
Module: cv32e40p_tmr_scrub_replicator

---
 rtl/cv32e40p_pkg.sv | 11 +
 rtl/cv32e40p_tmr_maj_word.sv | 22 ++
 rtl/cv32e40p_tmr_scrub_replicator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR scrub replicator slice.
// Holds the scrubber FSM state encoding.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIX   = 2'd2
    } scrub_state_e;

endpackage

// File: rtl/cv32e40p_tmr_maj_word.sv
// Bitwise 2-of-3 majority and pairwise mismatch flags for one entry.
// Ports: a/b/c copies in; maj, ne01, ne12, ne02 out (combinational).
module cv32e40p_tmr_maj_word
    import cv32e40p_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] maj,
    output logic             ne01,
    output logic             ne12,
    output logic             ne02
);

    assign maj  = (a & b) | (a & c) | (b & c);
    assign ne01 = (a != b);
    assign ne12 = (b != c);
    assign ne02 = (a != c);

endmodule

// File: rtl/cv32e40p_tmr_scrub_replicator.sv
// Triple-replicated register file with background majority scrubbing.
// Ports: clk/rst; we_i/waddr_i/wdata_i write; scrub_en_i; inj_* fault
// injection; copy0_o..copy2_o copies; err_o/uncorr_o/err_cnt_o/pass_done_o.
module cv32e40p_tmr_scrub_replicator
    import cv32e40p_pkg::*;
#(
    parameter int N_PMP_ENTRIES = 16,
    parameter int WIDTH         = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   we_i,
    input  logic [$clog2(N_PMP_ENTRIES)-1:0]       waddr_i,
    input  logic [WIDTH-1:0]                       wdata_i,
    input  logic                                   scrub_en_i,
    input  logic                                   inj_en_i,
    input  logic [1:0]                             inj_copy_i,
    input  logic [$clog2(N_PMP_ENTRIES)-1:0]       inj_addr_i,
    input  logic [$clog2(WIDTH)-1:0]               inj_bit_i,
    output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]    copy0_o,
    output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]    copy1_o,
    output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]    copy2_o,
    output logic                                   err_o,
    output logic                                   uncorr_o,
    output logic [15:0]                            err_cnt_o,
    output logic                                   pass_done_o
);

    localparam int AW = $clog2(N_PMP_ENTRIES);

    scrub_state_e     state;
    scrub_state_e     state_nxt;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] maj;
    logic             ne01;
    logic             ne12;
    logic             ne02;
    logic             mism;
    logic             all_diff;
    logic             fix_hit;
    logic             fix_apply;
    logic             ptr_adv;
    logic             ptr_last;
    logic             inj_ok;

    cv32e40p_tmr_maj_word #(.WIDTH(WIDTH)) u_maj (
        .a    (copy0_o[ptr]),
        .b    (copy1_o[ptr]),
        .c    (copy2_o[ptr]),
        .maj  (maj),
        .ne01 (ne01),
        .ne12 (ne12),
        .ne02 (ne02)
    );

    always_comb begin
        mism      = ne01 | ne12 | ne02;
        all_diff  = ne01 & ne12 & ne02;
        // A functional write to the entry being fixed supersedes the fix.
        fix_hit   = we_i && (waddr_i == ptr);
        fix_apply = (state == FIX) && !fix_hit;
        ptr_last  = (ptr == AW'(N_PMP_ENTRIES - 1));
        ptr_adv   = ((state == CHECK) && scrub_en_i && !mism)
                  || (state == FIX);
        inj_ok    = inj_en_i && (inj_copy_i != 2'd3)
                  && !(we_i && (waddr_i == inj_addr_i));
        state_nxt = state;
        unique case (state)
            IDLE:    if (scrub_en_i) state_nxt = CHECK;
            CHECK: begin
                if (!scrub_en_i) state_nxt = IDLE;
                else if (mism)   state_nxt = FIX;
            end
            FIX:     state_nxt = scrub_en_i ? CHECK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            err_o       <= 1'b0;
            uncorr_o    <= 1'b0;
            pass_done_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            state       <= state_nxt;
            err_o       <= fix_apply && mism;
            uncorr_o    <= fix_apply && all_diff;
            pass_done_o <= ptr_adv && ptr_last;
            if (ptr_adv)
                ptr <= ptr_last ? '0 : ptr + 1'b1;
            if (fix_apply && mism && (err_cnt_o != 16'hFFFF))
                err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

    // Later assignments win: write over injection, fix over injection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copy0_o <= '0;
            copy1_o <= '0;
            copy2_o <= '0;
        end else begin
            if (inj_ok) begin
                unique case (inj_copy_i)
                    2'd0: copy0_o[inj_addr_i][inj_bit_i] <=
                          ~copy0_o[inj_addr_i][inj_bit_i];
                    2'd1: copy1_o[inj_addr_i][inj_bit_i] <=
                          ~copy1_o[inj_addr_i][inj_bit_i];
                    2'd2: copy2_o[inj_addr_i][inj_bit_i] <=
                          ~copy2_o[inj_addr_i][inj_bit_i];
                    default: ;
                endcase
            end
            if (we_i) begin
                copy0_o[waddr_i] <= wdata_i;
                copy1_o[waddr_i] <= wdata_i;
                copy2_o[waddr_i] <= wdata_i;
            end
            if (fix_apply) begin
                copy0_o[ptr] <= maj;
                copy1_o[ptr] <= maj;
                copy2_o[ptr] <= maj;
            end
        end
    end

endmodule
